multi_master_arbiter: RTL and testbench

Parametrised N-master serial-bus arbiter, the successor to the two-master `serial_arbiter`. It keeps frame-atomic grants and runtime-selectable fixed-priority or round-robin arbitration. Splits are non-blocking: a split master is parked so other masters can use the bus, then wins top priority once its slave signals completion. It sits between the master request lines and the bus mux select, driven by the frame tracker and the slave split signals.

---
 rtl/bus_pkg.sv | 21 ++
 rtl/arb_rr_pick.sv | 39 +++
 rtl/multi_master_arbiter.sv | 174 +++++++++++++++++
 tb/tb_multi_master_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg: shared serial-bus definitions.
//   arb_state_e      - arbiter state encoding (idle / grant held / frame locked)
//   ARB_MODE_FIXED   - mode_rr_i value selecting fixed priority (index 0 highest)
//   ARB_MODE_RR      - mode_rr_i value selecting round-robin
//   ARB_MAX_MASTERS  - largest supported master count
// ---------------------------------------------------------------------------
package bus_pkg;

    localparam int unsigned ARB_MAX_MASTERS = 16;

    localparam logic ARB_MODE_FIXED = 1'b0;
    localparam logic ARB_MODE_RR    = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StFrame
    } arb_state_e;

endpackage

// File: rtl/arb_rr_pick.sv
// ---------------------------------------------------------------------------
// arb_rr_pick: combinational priority picker with a rotating start index.
// Scans req_i starting at start_i, wrapping at NUM_MASTERS, and reports the
// first set bit.
//   req_i    in  NUM_MASTERS  candidate set
//   start_i  in  MW           index searched first
//   found_o  out 1            candidate set non-empty
//   idx_o    out MW           winning index (0 when nothing found)
// ---------------------------------------------------------------------------
module arb_rr_pick
    import bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MW          = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [MW-1:0]          start_i,
    output logic                   found_o,
    output logic [MW-1:0]          idx_o
);

    always_comb begin
        int unsigned pos;
        logic [MW-1:0] pos_idx;
        found_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            pos     = (32'(start_i) + k) % NUM_MASTERS;
            pos_idx = MW'(pos);
            if (!found_o && req_i[pos_idx]) begin
                found_o = 1'b1;
                idx_o   = pos_idx;
            end
        end
    end

endmodule

// File: rtl/multi_master_arbiter.sv
// ---------------------------------------------------------------------------
// multi_master_arbiter: N-master serial-bus arbiter with frame-atomic grants,
// fixed-priority or round-robin selection and non-blocking splits.
//   clk_i, rst_i            clock, asynchronous active-high reset
//   mode_rr_i               0 fixed priority, 1 round-robin
//   req_i                   per-master request level
//   frame_active_i          high while a frame is on the bus
//   split_start_i           owner's slave issued a split (pulse)
//   split_done_i/_id_i      split for master id completed (pulse)
//   gnt_o, msel_o           registered one-hot grant and its index
//   split_pending_o         masters parked awaiting split completion
//   resume_o                masters whose split completed, not yet re-granted
// ---------------------------------------------------------------------------
module multi_master_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MW          = $clog2(NUM_MASTERS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   mode_rr_i,
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic                   frame_active_i,
    input  logic                   split_start_i,
    input  logic                   split_done_i,
    input  logic [MW-1:0]          split_done_id_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic [MW-1:0]          msel_o,
    output logic [NUM_MASTERS-1:0] split_pending_o,
    output logic [NUM_MASTERS-1:0] resume_o
);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [MW-1:0]          msel_q, msel_d;
    logic [MW-1:0]          last_q, last_d;
    logic [NUM_MASTERS-1:0] pend_q, pend_d;
    logic [NUM_MASTERS-1:0] res_q, res_d;

    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] cand;
    logic [NUM_MASTERS-1:0] done_mask;
    logic [NUM_MASTERS-1:0] win_onehot;
    logic [MW-1:0]          rr_start;
    logic [MW-1:0]          norm_start;
    logic                   res_found, norm_found, win_found;
    logic [MW-1:0]          res_idx, norm_idx, win_idx;

    assign eligible = req_i & ~pend_q;
    // On a frame-end handover the current owner must not win again.
    assign cand     = (state_q == StFrame) ? (eligible & ~gnt_q) : eligible;

    assign rr_start   = (last_q == MW'(NUM_MASTERS - 1)) ? '0 : last_q + MW'(1);
    assign norm_start = (mode_rr_i == ARB_MODE_RR) ? rr_start : '0;

    arb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .MW          (MW)
    ) u_pick_resume (
        .req_i   (cand & res_q),
        .start_i ('0),
        .found_o (res_found),
        .idx_o   (res_idx)
    );

    arb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .MW          (MW)
    ) u_pick_normal (
        .req_i   (cand),
        .start_i (norm_start),
        .found_o (norm_found),
        .idx_o   (norm_idx)
    );

    assign win_found = res_found | norm_found;
    assign win_idx   = res_found ? res_idx : norm_idx;

    // Decoded done id, qualified by the pending set; ids >= NUM_MASTERS never match.
    always_comb begin
        done_mask  = '0;
        win_onehot = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            done_mask[i]  = split_done_i && (split_done_id_i == MW'(i)) && pend_q[i];
            win_onehot[i] = (win_idx == MW'(i));
        end
    end

    always_comb begin
        logic do_grant;
        state_d  = state_q;
        gnt_d    = gnt_q;
        msel_d   = msel_q;
        last_d   = last_q;
        pend_d   = pend_q;
        res_d    = res_q;
        do_grant = 1'b0;

        if (split_start_i && (state_q != StIdle)) begin
            pend_d = pend_d | gnt_q;
        end
        pend_d = pend_d & ~done_mask;
        res_d  = res_d | done_mask;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    do_grant = 1'b1;
                end
            end
            StGrant: begin
                if (frame_active_i) begin
                    state_d = StFrame;
                end else if ((req_i & gnt_q) == '0) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    msel_d  = '0;
                end
            end
            StFrame: begin
                if (!frame_active_i) begin
                    // A split raised on the final frame cycle still parks the owner.
                    if ((gnt_q & (pend_q | {NUM_MASTERS{split_start_i}})) != '0) begin
                        state_d = StIdle;
                        gnt_d   = '0;
                        msel_d  = '0;
                    end else if ((mode_rr_i == ARB_MODE_RR) && win_found) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d = StGrant;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                msel_d  = '0;
            end
        endcase

        if (do_grant) begin
            state_d = StGrant;
            gnt_d   = win_onehot;
            msel_d  = win_idx;
            last_d  = win_idx;
            res_d   = res_d & ~win_onehot;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            msel_q  <= '0;
            last_q  <= MW'(NUM_MASTERS - 1);
            pend_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            msel_q  <= msel_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            res_q   <= res_d;
        end
    end

    assign gnt_o           = gnt_q;
    assign msel_o          = msel_q;
    assign split_pending_o = pend_q;
    assign resume_o        = res_q;

endmodule

// File: tb/tb_multi_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_multi_master_arbiter: directed scenarios plus randomized traffic for
// multi_master_arbiter (NUM_MASTERS = 4). A driver applies one input vector
// per cycle on the falling edge, advances a behavioural model and queues the
// expected outputs; a monitor pops and compares after each rising edge.
// ---------------------------------------------------------------------------
module tb_multi_master_arbiter;

    localparam int N  = 4;
    localparam int MW = 2;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [MW-1:0] msel;
        logic [N-1:0]  pend;
        logic [N-1:0]  res;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode_rr = 1'b0;
    logic [N-1:0]  req = '0;
    logic          frame = 1'b0;
    logic          ss = 1'b0;
    logic          sd = 1'b0;
    logic [MW-1:0] sdid = '0;
    logic [N-1:0]  gnt;
    logic [MW-1:0] msel;
    logic [N-1:0]  pend;
    logic [N-1:0]  res;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_a;

    // Model state: phase 0 idle, 1 granted, 2 granted and frame-locked.
    int           m_phase = 0;
    int           m_owner = -1;
    int           m_last = N - 1;
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_res = '0;

    multi_master_arbiter #(
        .NUM_MASTERS (N)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .mode_rr_i       (mode_rr),
        .req_i           (req),
        .frame_active_i  (frame),
        .split_start_i   (ss),
        .split_done_i    (sd),
        .split_done_id_i (sdid),
        .gnt_o           (gnt),
        .msel_o          (msel),
        .split_pending_o (pend),
        .resume_o        (res)
    );

    always #5 clk = ~clk;

    // Resumed masters first (lowest index), then lowest index or next after last winner.
    function automatic int choose(input logic [N-1:0] set, input logic rr);
        for (int i = 0; i < N; i++) if (set[i] && m_res[i]) return i;
        if (!rr) begin
            for (int i = 0; i < N; i++) if (set[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) if (set[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_step();
        logic [N-1:0] elig;
        logic [N-1:0] others;
        logic [N-1:0] np;
        logic [N-1:0] nr;
        int w;
        if (rst) begin
            m_phase = 0;
            m_owner = -1;
            m_last  = N - 1;
            m_pend  = '0;
            m_res   = '0;
            return;
        end
        elig = req & ~m_pend;
        np   = m_pend;
        nr   = m_res;
        w    = -1;
        if (ss && m_phase != 0) np[m_owner] = 1'b1;
        if (sd && int'(sdid) < N && m_pend[sdid]) begin
            np[sdid] = 1'b0;
            nr[sdid] = 1'b1;
        end
        case (m_phase)
            0: if (elig != '0) w = choose(elig, mode_rr);
            1: begin
                if (frame) m_phase = 2;
                else if (!req[m_owner]) begin
                    m_phase = 0;
                    m_owner = -1;
                end
            end
            default: begin
                if (!frame) begin
                    if (m_pend[m_owner] || ss) begin
                        m_phase = 0;
                        m_owner = -1;
                    end else begin
                        others = elig;
                        others[m_owner] = 1'b0;
                        if (mode_rr && others != '0) w = choose(others, mode_rr);
                        else m_phase = 1;
                    end
                end
            end
        endcase
        if (w >= 0) begin
            m_owner = w;
            m_phase = 1;
            m_last  = w;
            nr[w]   = 1'b0;
        end
        m_pend = np;
        m_res  = nr;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.gnt  = '0;
        e.msel = '0;
        if (m_phase != 0) begin
            e.gnt[m_owner] = 1'b1;
            e.msel = MW'(m_owner);
        end
        e.pend = m_pend;
        e.res  = m_res;
        return e;
    endfunction

    task automatic cyc(input logic r, input logic m, input logic [N-1:0] q, input logic f,
                       input logic s, input logic d, input logic [MW-1:0] id);
        @(negedge clk);
        rst = r; mode_rr = m; req = q; frame = f; ss = s; sd = d; sdid = id;
        model_step();
        exp_q.push_back(model_out());
    endtask

    // Assert reset between edges and check the outputs clear without a clock.
    task automatic reset_now();
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({gnt, msel, pend, res} != '0) begin
            miscompares++;
            $display("FAIL async_reset: got gnt=%b msel=%0d pend=%b res=%b, expected all zero",
                     gnt, msel, pend, res);
        end
        model_step();
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = '{gnt: gnt, msel: msel, pend: pend, res: res};
                vectors++;
                if (mon_a != mon_e) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got gnt=%b msel=%0d pend=%b res=%b, expected gnt=%b msel=%0d pend=%b res=%b",
                             $time, mon_a.gnt, mon_a.msel, mon_a.pend, mon_a.res,
                             mon_e.gnt, mon_e.msel, mon_e.pend, mon_e.res);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic          r_mode;
        logic [N-1:0]  r_req;
        logic          r_frame;
        // Reset state
        cyc(1, 0, 4'b0000, 0, 0, 0, 0);
        cyc(1, 0, 4'b0000, 0, 0, 0, 0);
        // Fixed priority: 1010 -> M1, then 1000 -> release then M3
        cyc(0, 0, 4'b1010, 0, 0, 0, 0);
        cyc(0, 0, 4'b1010, 0, 0, 0, 0);
        cyc(0, 0, 4'b1000, 0, 0, 0, 0);
        cyc(0, 0, 4'b1000, 0, 0, 0, 0);
        cyc(0, 0, 4'b1000, 0, 0, 0, 0);
        cyc(0, 0, 4'b0000, 0, 0, 0, 0);
        // Frame atomicity on M2
        cyc(0, 0, 4'b0100, 0, 0, 0, 0);
        cyc(0, 0, 4'b0100, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 4'b1111, 1, 0, 0, 0);
        cyc(0, 0, 4'b1111, 0, 0, 0, 0);
        cyc(0, 0, 4'b0000, 0, 0, 0, 0);
        cyc(0, 0, 4'b0000, 0, 0, 0, 0);
        // Round-robin handover from a fresh reset: M0, M1, M2, M3, M0
        cyc(1, 1, 4'b0000, 0, 0, 0, 0);
        cyc(0, 1, 4'b1111, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 4'b1111, 1, 0, 0, 0);
            cyc(0, 1, 4'b1111, 1, 0, 0, 0);
            cyc(0, 1, 4'b1111, 0, 0, 0, 0);
        end
        cyc(0, 1, 4'b0000, 0, 0, 0, 0);
        cyc(0, 1, 4'b0000, 0, 0, 0, 0);
        // Non-blocking split: M0 parks, M1 uses the bus, M0 resumes first
        cyc(1, 0, 4'b0000, 0, 0, 0, 0);
        cyc(0, 0, 4'b0001, 0, 0, 0, 0);
        cyc(0, 0, 4'b0001, 1, 0, 0, 0);
        cyc(0, 0, 4'b0001, 1, 1, 0, 0);
        cyc(0, 0, 4'b0011, 0, 0, 0, 0);
        cyc(0, 0, 4'b0011, 0, 0, 0, 0);
        cyc(0, 0, 4'b0011, 0, 0, 1, 0);
        cyc(0, 0, 4'b0011, 0, 0, 0, 0);
        cyc(0, 0, 4'b0001, 0, 0, 0, 0);
        cyc(0, 0, 4'b0001, 0, 0, 0, 0);
        cyc(0, 0, 4'b0001, 0, 0, 0, 0);
        cyc(0, 0, 4'b0000, 0, 0, 0, 0);
        cyc(0, 0, 4'b0000, 0, 0, 0, 0);
        // Simultaneous split start (owner M1) and split done (id 3)
        cyc(0, 0, 4'b1000, 0, 0, 0, 0);
        cyc(0, 0, 4'b1000, 1, 1, 0, 0);
        cyc(0, 0, 4'b0000, 0, 0, 0, 0);
        cyc(0, 0, 4'b0010, 0, 0, 0, 0);
        cyc(0, 0, 4'b0010, 1, 0, 0, 0);
        cyc(0, 0, 4'b0010, 1, 1, 1, 3);
        cyc(0, 0, 4'b0010, 1, 0, 1, 2);
        cyc(0, 0, 4'b0010, 1, 0, 0, 0);
        // Reset mid-frame with a pending split, then M2 request
        reset_now();
        cyc(1, 0, 4'b0000, 0, 0, 0, 0);
        cyc(0, 0, 4'b0100, 0, 0, 0, 0);
        cyc(0, 0, 4'b0100, 0, 0, 0, 0);
        cyc(0, 0, 4'b0000, 0, 0, 0, 0);
        // Randomized traffic
        r_mode  = 1'b0;
        r_req   = '0;
        r_frame = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) r_mode = ~r_mode;
            if ($urandom_range(0, 3) == 0) r_req = N'($urandom);
            if ($urandom_range(0, 3) == 0) r_frame = ~r_frame;
            cyc(($urandom_range(0, 499) == 0), r_mode, r_req, r_frame,
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                MW'($urandom_range(0, N - 1)));
        end
        cyc(0, 0, 4'b0000, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
